alu_packet_master: RTL

Parametrised hardware packet master for the UART ALU protocol. It turns a command (opcode plus up to `MAX_OPERANDS_P` operands) into a framed byte stream on an AXI-stream byte port feeding `uart` TX. It then collects the fixed-length little-endian result from `uart` RX, with a response timeout. It replaces hand-sequenced byte tasks on the icebreaker top and in benches, and serves as the on-chip self-test driver.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/byte_serializer.sv | 50 +++++
 rtl/alu_packet_master.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants, frame header layout and FSM state type for the UART ALU packet master.
package alu_pkg;

    localparam logic [7:0] OP_ECHO  = 8'hEC;
    localparam logic [7:0] OP_ADD32 = 8'hA0;
    localparam logic [7:0] OP_MUL32 = 8'h88;
    localparam logic [7:0] OP_DIV32 = 8'hD0;

    localparam int unsigned HDR_LEN = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_WAIT_RSP,
        ST_RSP
    } alu_master_state_e;

    // Header bytes in wire order, least significant byte first.
    typedef struct packed {
        logic [15:0] len;
        logic [7:0]  rsvd;
        logic [7:0]  opcode;
    } frame_hdr_t;

    // Total frame length in bytes, header included.
    function automatic logic [15:0] frame_len(input int unsigned count, input int unsigned bytes_per_op);
        return 16'(HDR_LEN + count * bytes_per_op);
    endfunction

endpackage

// File: rtl/byte_serializer.sv
// Loads a WIDTH_P-bit word and shifts it out least significant byte first over an AXI-stream handshake.
module byte_serializer #(
    parameter int unsigned WIDTH_P = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [WIDTH_P-1:0] word_i,
    output logic [7:0]         tdata_o,
    output logic               tvalid_o,
    input  logic               tready_i,
    output logic               word_done_c_o
);

    localparam int unsigned NBYTES = WIDTH_P / 8;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [WIDTH_P-1:0] shift_q;
    logic               valid_q;
    logic [IDX_W-1:0]   idx_q;
    logic               xfer_c;

    assign xfer_c        = valid_q & tready_i;
    assign word_done_c_o = xfer_c & (idx_q == IDX_W'(NBYTES - 1));
    assign tdata_o       = shift_q[7:0];
    assign tvalid_o      = valid_q;

    // A load on the final byte's handshake chains the next word with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else if (load_i) begin
            shift_q <= word_i;
            valid_q <= 1'b1;
            idx_q   <= '0;
        end else if (xfer_c) begin
            if (word_done_c_o) begin
                shift_q <= '0;
                valid_q <= 1'b0;
                idx_q   <= '0;
            end else begin
                shift_q <= shift_q >> 8;
                idx_q   <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_packet_master.sv
// Frames an ALU command onto the UART TX byte stream and collects the little-endian result from RX,
// giving up after TIMEOUT_CYCLES_P idle cycles between response bytes.
module alu_packet_master
    import alu_pkg::*;
#(
    parameter int unsigned MAX_OPERANDS_P   = 4,
    parameter int unsigned OPERAND_WIDTH_P  = 32,
    parameter int unsigned TIMEOUT_CYCLES_P = 1_000_000
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cmd_valid_i,
    output logic                                  cmd_ready_o,
    input  logic [7:0]                            cmd_opcode_i,
    input  logic [$clog2(MAX_OPERANDS_P+1)-1:0]   cmd_count_i,
    input  logic [MAX_OPERANDS_P*OPERAND_WIDTH_P-1:0] cmd_operands_i,
    output logic [7:0]                            m_axis_tdata_o,
    output logic                                  m_axis_tvalid_o,
    input  logic                                  m_axis_tready_i,
    input  logic [7:0]                            s_axis_tdata_i,
    input  logic                                  s_axis_tvalid_i,
    output logic                                  s_axis_tready_o,
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    output logic [OPERAND_WIDTH_P-1:0]            rsp_data_o,
    output logic                                  rsp_timeout_o,
    output logic                                  stray_byte_o
);

    localparam int unsigned CNT_W     = $clog2(MAX_OPERANDS_P + 1);
    localparam int unsigned OPS_W     = MAX_OPERANDS_P * OPERAND_WIDTH_P;
    localparam int unsigned NBYTES    = OPERAND_WIDTH_P / 8;
    localparam int unsigned RX_IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned TMR_W     = $clog2(TIMEOUT_CYCLES_P + 1);
    localparam int unsigned HDR_IDX_W = $clog2(HDR_LEN);

    alu_master_state_e          state_q;
    logic                       cmd_ready_q;
    logic                       s_tready_q;
    logic                       rsp_valid_q;
    logic                       rsp_timeout_q;
    logic                       stray_q;
    logic [OPERAND_WIDTH_P-1:0] rsp_data_q;
    logic [RX_IDX_W-1:0]        rx_idx_q;
    logic [TMR_W-1:0]           tmr_q;

    logic [7:0]                 hdr_tdata_q;
    logic                       hdr_tvalid_q;
    logic [23:0]                hdr_rest_q;
    logic [HDR_IDX_W-1:0]       hdr_idx_q;

    logic [OPS_W-1:0]           ops_q;
    logic [CNT_W-1:0]           ops_left_q;

    logic [CNT_W-1:0]           count_d;
    frame_hdr_t                 hdr_d;

    logic                       cmd_fire_c;
    logic                       hdr_xfer_c;
    logic                       hdr_last_c;
    logic                       rx_fire_c;
    logic                       ser_load_c;
    logic                       ser_done_c;
    logic [7:0]                 ser_tdata;
    logic                       ser_tvalid;

    // Saturated count and the header that goes with it.
    always_comb begin
        count_d = (cmd_count_i > CNT_W'(MAX_OPERANDS_P)) ? CNT_W'(MAX_OPERANDS_P) : cmd_count_i;
        hdr_d.opcode = cmd_opcode_i;
        hdr_d.rsvd   = 8'h00;
        hdr_d.len    = frame_len(32'(count_d), NBYTES);
    end

    assign cmd_fire_c = cmd_valid_i & cmd_ready_q;
    assign hdr_xfer_c = hdr_tvalid_q & m_axis_tready_i;
    assign hdr_last_c = hdr_xfer_c & (hdr_idx_q == HDR_IDX_W'(HDR_LEN - 1));
    assign rx_fire_c  = s_axis_tvalid_i & s_tready_q;
    assign ser_load_c = (hdr_last_c | ser_done_c) & (ops_left_q != '0);

    byte_serializer #(
        .WIDTH_P (OPERAND_WIDTH_P)
    ) u_ser (
        .clk           (clk),
        .rst           (rst),
        .load_i        (ser_load_c),
        .word_i        (ops_q[OPERAND_WIDTH_P-1:0]),
        .tdata_o       (ser_tdata),
        .tvalid_o      (ser_tvalid),
        .tready_i      (m_axis_tready_i),
        .word_done_c_o (ser_done_c)
    );

    // Operand queue: operand 0 always sits in the low word, ready for the next serializer load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_q      <= '0;
            ops_left_q <= '0;
        end else if (cmd_fire_c) begin
            ops_q      <= cmd_operands_i;
            ops_left_q <= count_d;
        end else if (ser_load_c) begin
            ops_q      <= ops_q >> OPERAND_WIDTH_P;
            ops_left_q <= ops_left_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            s_tready_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            stray_q       <= 1'b0;
            rsp_data_q    <= '0;
            rx_idx_q      <= '0;
            tmr_q         <= '0;
            hdr_tdata_q   <= '0;
            hdr_tvalid_q  <= 1'b0;
            hdr_rest_q    <= '0;
            hdr_idx_q     <= '0;
        end else begin
            stray_q <= rx_fire_c & (state_q != ST_WAIT_RSP);
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    s_tready_q  <= 1'b1;
                    if (cmd_fire_c) begin
                        state_q       <= ST_HDR;
                        cmd_ready_q   <= 1'b0;
                        hdr_tvalid_q  <= 1'b1;
                        hdr_tdata_q   <= hdr_d.opcode;
                        hdr_rest_q    <= {hdr_d.len, hdr_d.rsvd};
                        hdr_idx_q     <= '0;
                        rsp_data_q    <= '0;
                        rsp_timeout_q <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (hdr_last_c) begin
                        hdr_tvalid_q <= 1'b0;
                        hdr_tdata_q  <= '0;
                        hdr_idx_q    <= '0;
                        if (ops_left_q != '0) begin
                            state_q <= ST_DATA;
                        end else begin
                            state_q  <= ST_WAIT_RSP;
                            tmr_q    <= '0;
                            rx_idx_q <= '0;
                        end
                    end else if (hdr_xfer_c) begin
                        hdr_tdata_q <= hdr_rest_q[7:0];
                        hdr_rest_q  <= hdr_rest_q >> 8;
                        hdr_idx_q   <= hdr_idx_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (ser_done_c && (ops_left_q == '0)) begin
                        state_q  <= ST_WAIT_RSP;
                        tmr_q    <= '0;
                        rx_idx_q <= '0;
                    end
                end
                ST_WAIT_RSP: begin
                    // A byte landing on the limit cycle still counts and restarts the timer.
                    if (rx_fire_c) begin
                        for (int unsigned b = 0; b < NBYTES; b++) begin
                            if (rx_idx_q == RX_IDX_W'(b)) begin
                                rsp_data_q[8*b +: 8] <= s_axis_tdata_i;
                            end
                        end
                        tmr_q <= '0;
                        if (rx_idx_q == RX_IDX_W'(NBYTES - 1)) begin
                            state_q     <= ST_RSP;
                            rsp_valid_q <= 1'b1;
                            s_tready_q  <= 1'b0;
                        end else begin
                            rx_idx_q <= rx_idx_q + 1'b1;
                        end
                    end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES_P)) begin
                        state_q       <= ST_RSP;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        s_tready_q    <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready_i) begin
                        state_q       <= ST_IDLE;
                        rsp_valid_q   <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        cmd_ready_q   <= 1'b1;
                        s_tready_q    <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Header and serializer registers are zero whenever idle, so OR-ing them is a clean byte mux.
    assign m_axis_tdata_o  = hdr_tdata_q | ser_tdata;
    assign m_axis_tvalid_o = hdr_tvalid_q | ser_tvalid;
    assign cmd_ready_o     = cmd_ready_q;
    assign s_axis_tready_o = s_tready_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_data_o      = rsp_data_q;
    assign rsp_timeout_o   = rsp_timeout_q;
    assign stray_byte_o    = stray_q;

endmodule
